// File: rtl/controller_if.sv
// Handshake bundle between the instruction sequencer and the datapath it steers.
interface controller_if;
  logic [2:0] opcode;
  logic       zero;
  logic       run;
  logic       sel;
  logic       rd;
  logic       ld_ir;
  logic       halt;
  logic       inc_pc;
  logic       ld_ac;
  logic       ld_pc;
  logic       wr;
  logic       data_e;
  logic [2:0] phase;
  logic       halted;
  logic [7:0] instr_cnt;

  modport slave (
    input  opcode, zero, run,
    output sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e,
    output phase, halted, instr_cnt
  );

  modport master (
    output opcode, zero, run,
    input  sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e,
    input  phase, halted, instr_cnt
  );
endinterface

// File: rtl/controller_m.sv
// Eight-phase instruction sequencer: registered phase/halt/count state,
// control strobes decoded combinationally from phase, opcode and zero.
module controller_m (
  input  logic           clk,
  input  logic           rst_n,
  controller_if.slave    bus
);
  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  phase_t     phase_reg;
  logic       halted_reg;
  logic [7:0] cnt_reg;

  logic is_hlt;
  logic is_aluop;
  logic advance;

  assign is_hlt   = (bus.opcode == OP_HLT);
  assign is_aluop = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                    (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);
  assign advance  = bus.run && !halted_reg;

  // A HLT at OP_ADDR parks the sequencer there instead of advancing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg  <= INST_ADDR;
      halted_reg <= 1'b0;
      cnt_reg    <= 8'd0;
    end else if (advance) begin
      if (phase_reg == OP_ADDR && is_hlt) begin
        halted_reg <= 1'b1;
      end else begin
        phase_reg <= phase_t'(phase_reg + 3'd1);
        if (phase_reg == STORE) begin
          cnt_reg <= cnt_reg + 8'd1;
        end
      end
    end
  end

  logic sel_c, rd_c, ld_ir_c, halt_c, inc_pc_c, ld_ac_c, ld_pc_c, wr_c, data_e_c;

  always_comb begin
    sel_c    = 1'b0;
    rd_c     = 1'b0;
    ld_ir_c  = 1'b0;
    halt_c   = 1'b0;
    inc_pc_c = 1'b0;
    ld_ac_c  = 1'b0;
    ld_pc_c  = 1'b0;
    wr_c     = 1'b0;
    data_e_c = 1'b0;
    if (halted_reg) begin
      halt_c = 1'b1;
    end else begin
      case (phase_reg)
        INST_ADDR: sel_c = 1'b1;
        INST_FETCH: begin
          sel_c = 1'b1;
          rd_c  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel_c   = 1'b1;
          rd_c    = 1'b1;
          ld_ir_c = 1'b1;
        end
        OP_ADDR: begin
          inc_pc_c = 1'b1;
          halt_c   = is_hlt;
        end
        OP_FETCH: rd_c = is_aluop;
        ALU_OP: begin
          rd_c     = is_aluop;
          inc_pc_c = (bus.opcode == OP_SKZ) && bus.zero;
          ld_pc_c  = (bus.opcode == OP_JMP);
          data_e_c = (bus.opcode == OP_STO);
        end
        STORE: begin
          rd_c     = is_aluop;
          ld_ac_c  = is_aluop;
          ld_pc_c  = (bus.opcode == OP_JMP);
          wr_c     = (bus.opcode == OP_STO);
          data_e_c = (bus.opcode == OP_STO);
        end
        default: ;
      endcase
    end
  end

  assign bus.sel       = sel_c;
  assign bus.rd        = rd_c;
  assign bus.ld_ir     = ld_ir_c;
  assign bus.halt      = halt_c;
  assign bus.inc_pc    = inc_pc_c;
  assign bus.ld_ac     = ld_ac_c;
  assign bus.ld_pc     = ld_pc_c;
  assign bus.wr        = wr_c;
  assign bus.data_e    = data_e_c;
  assign bus.phase     = phase_reg;
  assign bus.halted    = halted_reg;
  assign bus.instr_cnt = cnt_reg;
endmodule

// File: tb/tb_controller_m.sv
// Bench for controller_m: directed scenarios with literal expectations plus
// randomized run/opcode/zero traffic checked every cycle against a phase model.
module tb_controller_m;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  controller_if bus();
  controller_m dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference state: phase number, sticky halt, completed-instruction count.
  int m_phase  = 0;
  bit m_halted = 1'b0;
  int m_cnt    = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase  <= 0;
      m_halted <= 1'b0;
      m_cnt    <= 0;
    end else if (bus.run && !m_halted) begin
      if (m_phase == 4 && bus.opcode == 3'd0) begin
        m_halted <= 1'b1;
      end else begin
        m_phase <= (m_phase + 1) % 8;
        if (m_phase == 7) m_cnt <= (m_cnt + 1) % 256;
      end
    end
  end

  // Expected strobes {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e}, one rule per signal.
  function automatic logic [8:0] exp_ctrl(input int ph, input logic [2:0] op,
                                          input logic z, input bit hl);
    bit aluop;
    logic [8:0] v;
    aluop = (op >= 3'd2) && (op <= 3'd5);
    if (hl) return 9'b000100000;
    v[8] = (ph < 4);
    v[7] = (ph >= 1 && ph <= 3) || (ph >= 5 && aluop);
    v[6] = (ph == 2 || ph == 3);
    v[5] = (ph == 4 && op == 3'd0);
    v[4] = (ph == 4) || (ph == 6 && op == 3'd1 && z);
    v[3] = (ph == 7 && aluop);
    v[2] = (ph == 6 || ph == 7) && op == 3'd7;
    v[1] = (ph == 7 && op == 3'd6);
    v[0] = (ph == 6 || ph == 7) && op == 3'd6;
    return v;
  endfunction

  always @(negedge clk) begin
    chk("ctrl", int'({bus.sel, bus.rd, bus.ld_ir, bus.halt, bus.inc_pc, bus.ld_ac,
                      bus.ld_pc, bus.wr, bus.data_e}),
        int'(exp_ctrl(m_phase, bus.opcode, bus.zero, m_halted)));
    chk("phase", int'(bus.phase), m_phase);
    chk("halted", int'(bus.halted), int'(m_halted));
    chk("instr_cnt", int'(bus.instr_cnt), m_cnt);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Asserts reset away from the clock edge and checks its asynchronous effect.
  task automatic do_reset;
    rst_n = 1'b0;
    #1;
    chk("rst_phase", int'(bus.phase), 0);
    chk("rst_halted", int'(bus.halted), 0);
    chk("rst_cnt", int'(bus.instr_cnt), 0);
    chk("rst_sel", int'(bus.sel), 1);
    chk("rst_others", int'({bus.rd, bus.ld_ir, bus.halt, bus.inc_pc, bus.ld_ac,
                            bus.ld_pc, bus.wr, bus.data_e}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.opcode = 3'd0;
    bus.zero   = 1'b0;
    bus.run    = 1'b0;
    #1;
    do_reset();

    // ADD: full sweep, accumulator load only in STORE.
    bus.opcode = 3'd2;
    bus.run    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("add_phase", int'(bus.phase), i);
      chk("add_ld_ac", int'(bus.ld_ac), int'(i == 7));
      tick();
    end
    chk("add_cnt", int'(bus.instr_cnt), 1);
    $display("scenario ADD sweep done, instr_cnt=%0d", bus.instr_cnt);

    // STO: drive in phases 6/7, write only in 7, no read after OP_ADDR.
    bus.run = 1'b0;
    do_reset();
    bus.opcode = 3'd6;
    bus.run    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("sto_data_e", int'(bus.data_e), int'(i == 6 || i == 7));
      chk("sto_wr", int'(bus.wr), int'(i == 7));
      if (i >= 5) chk("sto_rd", int'(bus.rd), 0);
      tick();
    end
    $display("scenario STO done");

    // SKZ with zero held only during ALU_OP; noise on zero elsewhere.
    for (int z = 0; z < 2; z++) begin
      bus.run = 1'b0;
      do_reset();
      bus.opcode = 3'd1;
      bus.run    = 1'b1;
      for (int i = 0; i < 8; i++) begin
        bus.zero = (i == 6) ? 1'(z) : 1'($urandom_range(0, 1));
        #1;
        chk("skz_inc_pc", int'(bus.inc_pc), int'(i == 4 || (i == 6 && z == 1)));
        tick();
      end
      $display("scenario SKZ zero=%0d done", z);
    end

    // HLT: parks at phase 4 with halt asserted.
    bus.run = 1'b0;
    do_reset();
    bus.opcode = 3'd0;
    bus.run    = 1'b1;
    repeat (4) tick();
    chk("hlt_halt", int'(bus.halt), 1);
    chk("hlt_pre_halted", int'(bus.halted), 0);
    tick();
    chk("hlt_halted", int'(bus.halted), 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hlt_phase", int'(bus.phase), 4);
      chk("hlt_inc_pc", int'(bus.inc_pc), 0);
      chk("hlt_hold", int'(bus.halt), 1);
    end
    do_reset();
    $display("scenario HLT done");

    // JMP frozen at STORE with run=0.
    bus.run = 1'b0;
    do_reset();
    bus.opcode = 3'd7;
    bus.run    = 1'b1;
    repeat (7) tick();
    bus.run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("jmp_phase", int'(bus.phase), 7);
      chk("jmp_ld_pc", int'(bus.ld_pc), 1);
      chk("jmp_cnt", int'(bus.instr_cnt), 0);
    end
    bus.run = 1'b1;
    tick();
    chk("jmp_cnt_after", int'(bus.instr_cnt), 1);
    chk("jmp_phase_after", int'(bus.phase), 0);
    $display("scenario JMP hold done");

    // 256 ADDs wrap the counter; then reset mid-instruction at phase 5.
    bus.run = 1'b0;
    do_reset();
    bus.opcode = 3'd2;
    bus.run    = 1'b1;
    repeat (255 * 8) tick();
    chk("wrap_cnt_255", int'(bus.instr_cnt), 255);
    repeat (8) tick();
    chk("wrap_cnt_0", int'(bus.instr_cnt), 0);
    repeat (5) tick();
    chk("wrap_phase5", int'(bus.phase), 5);
    do_reset();
    $display("scenario counter wrap and mid-instruction reset done");

    // Random traffic; opcode only changes before OP_ADDR.
    for (int c = 0; c < 4000; c++) begin
      if (m_phase == 0 && !m_halted)
        bus.opcode = ($urandom_range(0, 15) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      bus.run  = ($urandom_range(0, 3) != 0);
      bus.zero = 1'($urandom_range(0, 1));
      if ((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0)
        do_reset();
      else
        tick();
    end
    $display("random phase done, %0d instructions last counted", m_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/controller_m.md
CONTROLLER_M -- requirements
Module: controller_m

Interface
REQ-001 Parameter: none; opcode width fixed at 3 bits; encoding HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  3  instruction opcode from the external instruction register; stable from phase OP_ADDR through STORE.
REQ-005 zero  input  1  ALU accumulator-is-zero flag.
REQ-006 run  input  1  phase-advance enable; 0 freezes the sequencer.
REQ-007 sel  output  1  address mux select: 1 = PC, 0 = instruction operand.
REQ-008 rd  output  1  memory read enable.
REQ-009 ld_ir  output  1  instruction register load.
REQ-010 halt  output  1  halt-decode strobe.
REQ-011 inc_pc  output  1  program counter increment.
REQ-012 ld_ac  output  1  accumulator load.
REQ-013 ld_pc  output  1  program counter load (jump).
REQ-014 wr  output  1  memory write enable.
REQ-015 data_e  output  1  accumulator-to-data-bus drive enable.
REQ-016 phase  output  3  current phase, 0..7.
REQ-017 halted  output  1  sticky halted status.
REQ-018 instr_cnt  output  8  count of completed instructions.

Function
REQ-019 Phases SHALL be INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7.
REQ-020 When run=1 and halted=0, phase SHALL advance by 1 per clock, wrapping STORE->INST_ADDR.
REQ-021 When run=0, phase, halted and instr_cnt SHALL hold; outputs keep decoding the held phase, and multi-cycle strobes are permitted.
REQ-022 Control outputs SHALL be a combinational decode of phase, opcode and zero; any signal not listed for a phase is 0.
REQ-023 Define ALUOP = opcode in {ADD, AND, XOR, LDA}.
REQ-024 INST_ADDR: sel=1.
REQ-025 INST_FETCH: sel=1, rd=1.
REQ-026 INST_LOAD and IDLE: sel=1, rd=1, ld_ir=1.
REQ-027 OP_ADDR: inc_pc=1, halt=(opcode==HLT).
REQ-028 OP_FETCH: rd=ALUOP.
REQ-029 ALU_OP: rd=ALUOP, inc_pc=(opcode==SKZ && zero), ld_pc=(opcode==JMP), data_e=(opcode==STO).
REQ-030 STORE: rd=ALUOP, ld_ac=ALUOP, ld_pc=(opcode==JMP), wr=(opcode==STO), data_e=(opcode==STO).
REQ-031 At OP_ADDR with opcode==HLT and run=1, halted SHALL set on that clock edge; thereafter phase SHALL remain OP_ADDR.
REQ-032 While halted=1, all control outputs except halt SHALL be forced to 0; halt SHALL stay 1.
REQ-033 Only reset SHALL clear halted.
REQ-034 instr_cnt SHALL increment by 1 modulo 256 on each STORE->INST_ADDR transition, and SHALL not increment for a halted HLT instruction.
REQ-035 zero SHALL be sampled only combinationally during ALU_OP; a zero change in other phases has no effect.

Reset
REQ-036 While rst_n=0, phase=0, halted=0 and instr_cnt=0 immediately, independent of clk; outputs therefore decode INST_ADDR (sel=1, all others 0).
REQ-037 A reset asserted mid-instruction SHALL abandon it without completing the write or load; the first phase after rst_n rises is INST_ADDR, and the first advance occurs on the first rising clk edge with run=1.

Verification
REQ-038 Reset, then run=1 with opcode=ADD -> phase steps 0..7 over 8 clocks; ld_ac=1 only in phase 7; instr_cnt=1 after the 8th edge.
REQ-039 opcode=STO -> data_e=1 in phases 6 and 7, wr=1 only in phase 7, and rd=0 in phases 5..7.
REQ-040 opcode=SKZ with zero=1 -> inc_pc=1 in phases 4 and 6; with zero=0 -> inc_pc=1 in phase 4 only.
REQ-041 opcode=HLT -> halt=1 at phase 4, halted=1 after that edge, and phase stays 4 for 20 further clocks with inc_pc=0; rst_n pulse -> phase=0, halted=0.
REQ-042 run=0 for 5 clocks at phase 7 with opcode=JMP -> phase holds at 7 and ld_pc=1 throughout; instr_cnt increments once after run returns to 1.
REQ-043 256 ADD instructions after reset -> instr_cnt wraps to 0; rst_n asserted at phase 5 -> phase=0 asynchronously.
